// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv shared types
// op encodings and FSM state encodings
package ex_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int CNT_W = 6;

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv EX-stage bundle
// operands/controls in, stall and HI/LO write out
interface ex_muldiv_if
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             flushE;
  logic             hold;
  logic             op_valid;
  op_e              op;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             stall_req;
  logic             hilo_we;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output flushE, hold, op_valid, op,
    output srcaE, srcbE,
    input  stall_req, hilo_we, hi_o, lo_o
  );

  modport slave (
    input  flushE, hold, op_valid, op,
    input  srcaE, srcbE,
    output stall_req, hilo_we, hi_o, lo_o
  );
endinterface

// File: rtl/ex_muldiv_div_radix2.sv
// div_radix2: restoring radix-2 divider on magnitudes
// one quotient bit per cycle, WIDTH steps
module div_radix2
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             last_o,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o
);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shf, trial;

  // operand magnitudes and one shift-subtract step
  always_comb begin
    a_mag = (signed_i & a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag = (signed_i & b_i[WIDTH-1]) ? -b_i : b_i;
    shf   = {rem_q, quo_q[WIDTH-1]};
    trial = shf - {1'b0, dvs_q};
    rem_d = trial[WIDTH] ? shf[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  assign busy_o = busy_q;
  assign last_o = busy_q & (cnt_q == CNT_W'(WIDTH - 1));
  assign q_o    = quo_q;
  assign r_o    = rem_q;

  // iteration state; abort drops the run, data is don't-care
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (abort_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      quo_q  <= a_mag;
      rem_q  <= '0;
      dvs_q  <= b_mag;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      if (last_o) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage MULT/MULTU/DIV/DIVU unit
// FSM, multiplier, sign fix-up and stall handshake
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             div_start, div_abort;
  logic             div_busy, div_last;
  logic [WIDTH-1:0] div_q, div_r;

  logic [2*WIDTH-1:0] ma, mb, prod;
  logic               neg_q, neg_r, dz;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign div_start = (state_q == S_IDLE) & bus.op_valid
                   & ~bus.flushE & bus.op[1]
                   & (bus.srcbE != '0);
  assign div_abort = bus.flushE;

  div_radix2 #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start_i  (div_start),
    .abort_i  (div_abort),
    .signed_i (bus.op == OP_DIV),
    .a_i      (bus.srcaE),
    .b_i      (bus.srcbE),
    .busy_o   (div_busy),
    .last_o   (div_last),
    .q_o      (div_q),
    .r_o      (div_r)
  );

  // full-width product and divide sign correction
  always_comb begin
    ma = (op_q == OP_MULT) ? {{WIDTH{a_q[WIDTH-1]}}, a_q}
                           : {{WIDTH{1'b0}}, a_q};
    mb = (op_q == OP_MULT) ? {{WIDTH{b_q[WIDTH-1]}}, b_q}
                           : {{WIDTH{1'b0}}, b_q};
    prod  = ma * mb;
    dz    = (b_q == '0);
    neg_q = (op_q == OP_DIV) & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    neg_r = (op_q == OP_DIV) & a_q[WIDTH-1];
    quo_fix = neg_q ? -div_q : div_q;
    rem_fix = neg_r ? -div_r : div_r;
    if (dz) begin
      quo_fix = '1;
      rem_fix = a_q;
    end
  end

  assign bus.stall_req = bus.op_valid & (state_q != S_DONE)
                       & ~bus.flushE;
  assign bus.hilo_we   = (state_q == S_DONE) & ~bus.flushE
                       & ~bus.hold;
  assign bus.hi_o      = hi_q;
  assign bus.lo_o      = lo_q;

  // control FSM with registered HI/LO results
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (bus.flushE) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.op_valid) begin
            op_q <= bus.op;
            a_q  <= bus.srcaE;
            b_q  <= bus.srcbE;
            if (!bus.op[1])             state_q <= S_MUL;
            else if (bus.srcbE == '0)   state_q <= S_FIX;
            else                        state_q <= S_DIV;
          end
        end
        S_MUL: begin
          {hi_q, lo_q} <= prod;
          state_q      <= S_DONE;
        end
        S_DIV: begin
          if (div_last) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= rem_fix;
          lo_q    <= quo_fix;
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (!bus.hold) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed + random checks of ex_muldiv
// against a plain-arithmetic HI/LO model
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [31:0] last_hi, last_lo;

  always #5 clk = ~clk;

  ex_muldiv_if #(.WIDTH(32)) bus ();

  ex_muldiv #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r, p;
    longint unsigned ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    if (op == 2'b00) begin
      p = sa * sb;
      return p;
    end
    if (op == 2'b01) return ua * ub;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == 2'b10) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic run_op(input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input bit drop);
    int stalls, exp_st;
    logic [63:0] m;
    m      = model(op, a, b);
    exp_st = (op[1] && b != 0) ? 34 : 2;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op       = op_e'(op);
    bus.srcaE    = a;
    bus.srcbE    = b;
    #1;
    stalls = 0;
    while (bus.stall_req && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check($sformatf("stalls op%0d", op), stalls, exp_st);
    check($sformatf("we op%0d", op), 32'(bus.hilo_we), 32'd1);
    check($sformatf("hi op%0d %h/%h", op, a, b), bus.hi_o, m[63:32]);
    check($sformatf("lo op%0d %h/%h", op, a, b), bus.lo_o, m[31:0]);
    last_hi = m[63:32];
    last_lo = m[31:0];
    if (drop) begin
      @(negedge clk);
      bus.op_valid = 1'b0;
      #1;
      check("single_we", 32'(bus.hilo_we), 32'd0);
    end
  endtask

  initial begin
    int seen_we;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] m;

    rst          = 1'b1;
    bus.flushE   = 1'b0;
    bus.hold     = 1'b0;
    bus.op_valid = 1'b0;
    bus.op       = OP_MULT;
    bus.srcaE    = '0;
    bus.srcbE    = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst hi", bus.hi_o, 32'd0);
    check("rst lo", bus.lo_o, 32'd0);
    check("rst stall", 32'(bus.stall_req), 32'd0);
    check("rst we", 32'(bus.hilo_we), 32'd0);
    rst = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1);
    run_op(2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 1);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1);
    run_op(2'b11, 32'd100, 32'd7, 1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_op(2'b11, 32'd5, 32'd0, 1);
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 1);

    // back-to-back without a dropped op_valid cycle
    run_op(2'b10, 32'd1000, 32'hFFFF_FFFD, 0);
    run_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 1);

    // flush at divide iteration 10
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op       = OP_DIVU;
    bus.srcaE    = 32'd12345;
    bus.srcbE    = 32'd17;
    repeat (11) @(negedge clk);
    bus.flushE = 1'b1;
    #1;
    check("flush stall", 32'(bus.stall_req), 32'd0);
    check("flush we", 32'(bus.hilo_we), 32'd0);
    @(negedge clk);
    bus.flushE   = 1'b0;
    bus.op_valid = 1'b0;
    #1;
    check("postflush stall", 32'(bus.stall_req), 32'd0);
    check("postflush hi", bus.hi_o, last_hi);
    check("postflush lo", bus.lo_o, last_lo);
    seen_we = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (bus.hilo_we) seen_we++;
    end
    check("postflush no we", seen_we, 0);
    check("postflush hi2", bus.hi_o, last_hi);
    run_op(2'b01, 32'd9, 32'd9, 1);

    // hold during DONE
    bus.hold = 1'b1;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op       = OP_DIV;
    bus.srcaE    = 32'hFFFF_FC00;
    bus.srcbE    = 32'd33;
    m = model(2'b10, 32'hFFFF_FC00, 32'd33);
    repeat (34) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("hold we %0d", i), 32'(bus.hilo_we), 32'd0);
      check($sformatf("hold stall %0d", i), 32'(bus.stall_req), 32'd0);
      check($sformatf("hold hi %0d", i), bus.hi_o, m[63:32]);
      check($sformatf("hold lo %0d", i), bus.lo_o, m[31:0]);
      @(negedge clk);
    end
    bus.hold = 1'b0;
    #1;
    check("hold release we", 32'(bus.hilo_we), 32'd1);
    check("hold release lo", bus.lo_o, m[31:0]);
    @(negedge clk);
    bus.op_valid = 1'b0;
    #1;
    check("hold single we", 32'(bus.hilo_we), 32'd0);

    // reset mid-MUL
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op       = OP_MULT;
    bus.srcaE    = 32'h1234_5678;
    bus.srcbE    = 32'h9ABC_DEF0;
    @(negedge clk);
    rst          = 1'b1;
    bus.op_valid = 1'b0;
    @(negedge clk);
    #1;
    check("midrst hi", bus.hi_o, 32'd0);
    check("midrst lo", bus.lo_o, 32'd0);
    check("midrst stall", 32'(bus.stall_req), 32'd0);
    check("midrst we", 32'(bus.hilo_we), 32'd0);
    rst = 1'b0;
    run_op(2'b01, 32'd3, 32'd4, 1);

    // random operations
    for (int k = 0; k < 24; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
      run_op(rop, ra, rb, $urandom_range(0, 1) == 1);
    end

    @(negedge clk);
    bus.op_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
